slt_exec_stage: RTL and testbench



---
 rtl/slt_exec_stage.sv | 167 ++++++++++++++++
 tb/tb_slt_exec_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slt_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : slt_exec_stage
// Purpose  : Four-state execute stage (IDLE -> READ -> EXEC -> WB) around a
//            signed/unsigned set-less-than and add/subtract datapath, with an
//            NREG x n register file, preload port and debug read port.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready   command handshake, op/rs/rt/rd command fields
//            ld_en/ld_addr/ld_data  register preload (IDLE only)
//            dbg_addr/dbg_data   combinational register read
//            done/result/ovf     registered write-back report
// Revision : 1.0 - initial release
// ============================================================================
module slt_exec_stage #(
  parameter int n    = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [4:0]   rs,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic         ld_en,
  input  logic [4:0]   ld_addr,
  input  logic [n-1:0] ld_data,
  input  logic [4:0]   dbg_addr,
  output logic [n-1:0] dbg_data,
  output logic         done,
  output logic [n-1:0] result,
  output logic         ovf
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t       state, state_nx;
  logic [1:0]   op_q;
  logic [4:0]   rs_q, rt_q, rd_q;
  logic [n-1:0] a_q, b_q;
  logic [n-1:0] regs [NREG];

  // R0 and any address beyond NREG read as zero.
  function automatic logic [n-1:0] rf_read(input logic [4:0] addr);
    if (addr == 5'd0 || int'(addr) >= NREG) return '0;
    return regs[addr];
  endfunction

  function automatic logic rf_writable(input logic [4:0] addr);
    return (addr != 5'd0) && (int'(addr) < NREG);
  endfunction

  assign in_ready = (state == S_IDLE);
  assign dbg_data = rf_read(dbg_addr);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_READ;
      S_READ:  state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command capture and operand read
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        op_q <= op;
        rs_q <= rs;
        rt_q <= rt;
        rd_q <= rd;
      end
      // A same-edge preload in IDLE has already landed in regs by now.
      if (state == S_READ) begin
        a_q <= rf_read(rs_q);
        b_q <= rf_read(rt_q);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: one shared subtractor feeds SUB, SLT and SLTU
  // --------------------------------------------------------------------------
  logic [n-1:0] sum, diff, y;
  logic         cout, add_ovf, sub_ovf, lt, ovf_nx;

  always_comb begin
    sum           = a_q + b_q;
    {cout, diff}  = {1'b0, a_q} + {1'b0, ~b_q} + {{n{1'b0}}, 1'b1};
    add_ovf       = (a_q[n-1] == b_q[n-1]) && (sum[n-1]  != a_q[n-1]);
    sub_ovf       = (a_q[n-1] != b_q[n-1]) && (diff[n-1] != a_q[n-1]);
    // Sign of the difference is wrong exactly when the subtract overflowed.
    lt            = diff[n-1] ^ sub_ovf;
    y             = sum;
    ovf_nx        = 1'b0;
    case (op_q)
      OP_ADD:  begin y = sum;  ovf_nx = add_ovf; end
      OP_SUB:  begin y = diff; ovf_nx = sub_ovf; end
      OP_SLT:  y = {{(n-1){1'b0}}, lt};
      OP_SLTU: y = {{(n-1){1'b0}}, ~cout};
      default: y = sum;
    endcase
  end

  // result doubles as the Y latch: it is loaded at the EXEC edge and
  // written into R[rd] at the WB edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      done <= (state == S_EXEC);
      if (state == S_EXEC) begin
        result <= y;
        ovf    <= ovf_nx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (state == S_IDLE && ld_en && rf_writable(ld_addr))
        regs[ld_addr] <= ld_data;
      if (state == S_WB && rf_writable(rd_q))
        regs[rd_q] <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slt_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_slt_exec_stage
// Purpose  : Directed self-checking bench for slt_exec_stage. Expected
//            write-back values come from a reference model over a shadow
//            register file and are queued at command accept; a monitor pops
//            and compares them when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slt_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  slt_exec_stage #(.n(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] y;
    logic        o;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mreg [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the arithmetic definitions.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic signed [32:0] w;
    e.acc = 0;
    e.o   = 1'b0;
    case (o)
      2'b00: begin
        w   = $signed({a[31], a}) + $signed({b[31], b});
        e.y = w[31:0];
        e.o = (w[32] != w[31]);
      end
      2'b01: begin
        w   = $signed({a[31], a}) - $signed({b[31], b});
        e.y = w[31:0];
        e.o = (w[32] != w[31]);
      end
      2'b10:   e.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.y = (a < b) ? 32'd1 : 32'd0;
    endcase
    return e;
  endfunction

  // Scoreboard monitor: every done must match the oldest queued command.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.y);
        check("ovf", 32'(ovf), 32'(e.o));
        check("done_latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (a != 5'd0) mreg[a] = v;
  endtask

  // Drives a command, returns at #1 after the accept edge with its cycle.
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input bit keep, input bit with_ld,
                       input logic [4:0] la, input logic [31:0] lv,
                       input bit expect_wb, output int acc);
    int   waits;
    exp_t e;
    waits = 0;
    op = o; rs = s; rt = t; rd = d; in_valid = 1'b1;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    if (with_ld) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    @(posedge clk); #1;
    acc      = cyc;
    in_valid = keep;
    ld_en    = 1'b0;
    if (with_ld && la != 5'd0) mreg[la] = lv;
    e     = model(o, mreg[s], mreg[t]);
    e.acc = acc;
    if (expect_wb) begin
      sb.push_back(e);
      if (d != 5'd0) mreg[d] = e.y;
    end
  endtask

  task automatic wait_wb();
    repeat (3) @(posedge clk);
    #1;
  endtask

  int a1, a2;

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = '0;

    // Reset state, observed while rst_n is still low.
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed vs unsigned compare.
    preload(5'd1, 32'd5);
    preload(5'd2, 32'hFFFF_FFFD);
    chk_reg("r1_preload", 5'd1, 32'd5);
    chk_reg("r2_preload", 5'd2, 32'hFFFF_FFFD);
    issue(2'b10, 5'd2, 5'd1, 5'd3, 0, 0, 5'd0, 32'd0, 1, a1);
    check("busy_after_accept", 32'(in_ready), 32'd0);
    wait_wb();
    check("ready_after_wb", 32'(in_ready), 32'd1);
    chk_reg("r3_slt", 5'd3, 32'd1);
    issue(2'b11, 5'd2, 5'd1, 5'd4, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r4_sltu", 5'd4, 32'd0);

    // Overflow.
    preload(5'd5, 32'h7FFF_FFFF);
    preload(5'd6, 32'd1);
    issue(2'b00, 5'd5, 5'd6, 5'd7, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r7_add_ovf", 5'd7, 32'h8000_0000);
    issue(2'b10, 5'd7, 5'd5, 5'd8, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r8_slt_ovf", 5'd8, 32'd1);
    preload(5'd9, 32'h0000_DEAD);
    issue(2'b01, 5'd1, 5'd1, 5'd9, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r9_sub_zero", 5'd9, 32'd0);
    issue(2'b10, 5'd1, 5'd1, 5'd13, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r13_slt_equal", 5'd13, 32'd0);

    // R0 handling.
    issue(2'b00, 5'd1, 5'd1, 5'd0, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r0_after_wb", 5'd0, 32'd0);
    check("result_held", result, 32'd10);
    preload(5'd0, 32'h55);
    chk_reg("r0_after_preload", 5'd0, 32'd0);

    // Back-pressure: valid held across two commands.
    issue(2'b00, 5'd1, 5'd1, 5'd14, 1, 0, 5'd0, 32'd0, 1, a1);
    issue(2'b01, 5'd2, 5'd1, 5'd15, 0, 0, 5'd0, 32'd0, 1, a2);
    check("b2b_accept_gap", 32'(a2 - a1), 32'd4);
    wait_wb();
    chk_reg("r14_b2b", 5'd14, 32'd10);
    chk_reg("r15_b2b", 5'd15, 32'hFFFF_FFF8);

    // Preload while busy is dropped.
    issue(2'b00, 5'd5, 5'd1, 5'd16, 0, 0, 5'd0, 32'd0, 1, a1);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'h1234;
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(posedge clk); #1;
    chk_reg("r10_ld_dropped", 5'd10, 32'd0);
    chk_reg("r16_add", 5'd16, 32'h8000_0004);

    // Same-edge preload and accept.
    issue(2'b01, 5'd2, 5'd1, 5'd11, 0, 1, 5'd2, 32'd9, 1, a1);
    wait_wb();
    chk_reg("r11_same_edge", 5'd11, 32'd4);

    // Reset abort during EXEC.
    issue(2'b00, 5'd1, 5'd1, 5'd12, 0, 0, 5'd0, 32'd0, 0, a1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready_in_reset", 32'(in_ready), 32'd1);
    check("abort_result_in_reset", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_result", result, 32'd0);
    chk_reg("abort_r12", 5'd12, 32'd0);
    chk_reg("abort_r1_cleared", 5'd1, 32'd0);

    // Recovery after reset.
    preload(5'd1, 32'd5);
    issue(2'b00, 5'd1, 5'd1, 5'd12, 0, 0, 5'd0, 32'd0, 1, a1);
    wait_wb();
    chk_reg("r12_recovery", 5'd12, 32'd10);

    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
